// File: rtl/axi_4_lite_mst_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes, default widths
// and the master FSM state encoding.
package axi_4_lite_mst_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [2:0] AXPROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // States in which a transaction is waiting on the slave.
    function automatic logic is_busy(input state_t s);
        return s inside {ST_WRITE, ST_WRESP, ST_RADDR, ST_RDATA};
    endfunction

endpackage

// File: rtl/axi_4_lite_mst_if.sv
// Command/response port plus the five AXI4-Lite channels of the master.
// The master modport is the DUT view; the slave modport is the far side.
interface axi_4_lite_mst_if
    import axi_4_lite_mst_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = DEF_ADDR_W,
    parameter int C_AXI_DATA_WIDTH = DEF_DATA_W
);
    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_write;
    logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr;
    logic [C_AXI_DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_W-1:0]           cmd_wstrb;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [C_AXI_DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]                  rsp_resp;
    logic                        rsp_timeout;

    logic                        M_AXI_AWVALID;
    logic                        M_AXI_AWREADY;
    logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic [2:0]                  M_AXI_AWPROT;
    logic                        M_AXI_WVALID;
    logic                        M_AXI_WREADY;
    logic [C_AXI_DATA_WIDTH-1:0] M_AXI_WDATA;
    logic [STRB_W-1:0]           M_AXI_WSTRB;
    logic                        M_AXI_BVALID;
    logic                        M_AXI_BREADY;
    logic [1:0]                  M_AXI_BRESP;
    logic                        M_AXI_ARVALID;
    logic                        M_AXI_ARREADY;
    logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [2:0]                  M_AXI_ARPROT;
    logic                        M_AXI_RVALID;
    logic                        M_AXI_RREADY;
    logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]                  M_AXI_RRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        input  rsp_ready,
        output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
        input  M_AXI_AWREADY,
        output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
        input  M_AXI_WREADY,
        input  M_AXI_BVALID, M_AXI_BRESP,
        output M_AXI_BREADY,
        output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
        input  M_AXI_ARREADY,
        input  M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
        output M_AXI_RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        output rsp_ready,
        input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
        output M_AXI_AWREADY,
        input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
        output M_AXI_WREADY,
        output M_AXI_BVALID, M_AXI_BRESP,
        input  M_AXI_BREADY,
        input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
        output M_AXI_ARREADY,
        output M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/axi_4_lite_timeout.sv
// Transaction watchdog: counts enabled cycles since clear and flags expiry on
// the C_TIMEOUT_CYCLES-th one. A limit of 0 disables it entirely.
module axi_4_lite_timeout #(
    parameter int C_TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (C_TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst_n, clear, enable};
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(C_TIMEOUT_CYCLES + 1);
            logic [CW-1:0] cnt;

            // Expiry is combinational so the FSM leaves on exactly the N-th busy cycle.
            assign expired = enable && (cnt == CW'(C_TIMEOUT_CYCLES - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable && !expired) begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/axi_4_lite_mst.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out,
// one response back. Every output is a register loaded from the next-state logic.
module axi_4_lite_mst
    import axi_4_lite_mst_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = DEF_ADDR_W,
    parameter int C_AXI_DATA_WIDTH = DEF_DATA_W,
    parameter int C_TIMEOUT_CYCLES = 256
) (
    input  logic             M_AXI_ACLK,
    input  logic             M_AXI_ARESETN,
    axi_4_lite_mst_if.master bus
);
    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;

    state_t                      state_q, state_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic                        cmd_ready_q, cmd_ready_d;
    logic                        awvalid_q, awvalid_d;
    logic [C_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                        wvalid_q, wvalid_d;
    logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]           wstrb_q, wstrb_d;
    logic                        bready_q, bready_d;
    logic                        arvalid_q, arvalid_d;
    logic [C_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                        rready_q, rready_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [C_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                  rsp_resp_q, rsp_resp_d;
    logic                        rsp_timeout_q, rsp_timeout_d;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic busy, expired, abort;

    assign cmd_hs = bus.cmd_valid && cmd_ready_q;
    assign aw_hs  = awvalid_q && bus.M_AXI_AWREADY;
    assign w_hs   = wvalid_q && bus.M_AXI_WREADY;
    assign b_hs   = bready_q && bus.M_AXI_BVALID;
    assign ar_hs  = arvalid_q && bus.M_AXI_ARREADY;
    assign r_hs   = rready_q && bus.M_AXI_RVALID;
    assign busy   = is_busy(state_q);

    axi_4_lite_timeout #(
        .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (M_AXI_ACLK),
        .rst_n  (M_AXI_ARESETN),
        .clear  (cmd_hs),
        .enable (busy),
        .expired(expired)
    );

    always_comb begin
        state_d       = state_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        awaddr_d      = awaddr_q;
        wvalid_d      = wvalid_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_hs) begin
                    cmd_ready_d   = 1'b0;
                    aw_done_d     = 1'b0;
                    w_done_d      = 1'b0;
                    rsp_timeout_d = 1'b0;
                    if (bus.cmd_write) begin
                        state_d   = ST_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = bus.cmd_addr;
                        wdata_d   = bus.cmd_wdata;
                        wstrb_d   = bus.cmd_wstrb;
                    end else begin
                        state_d   = ST_RADDR;
                        arvalid_d = 1'b1;
                        araddr_d  = bus.cmd_addr;
                    end
                end
            end
            ST_WRITE: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (expired) begin
                    abort = 1'b1;
                end else if (aw_done_d && w_done_d) begin
                    state_d  = ST_WRESP;
                    bready_d = 1'b1;
                end
            end
            ST_WRESP: begin
                // A response arriving on the expiry cycle is kept.
                if (b_hs) begin
                    state_d       = ST_RESP;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = bus.M_AXI_BRESP;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            ST_RADDR: begin
                if (expired) begin
                    abort = 1'b1;
                end else if (ar_hs) begin
                    state_d   = ST_RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_RDATA: begin
                if (r_hs) begin
                    state_d       = ST_RESP;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = bus.M_AXI_RRESP;
                    rsp_rdata_d   = bus.M_AXI_RDATA;
                    rsp_timeout_d = 1'b0;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abandon the AXI transaction outright; the interconnect needs a reset after this.
        if (abort) begin
            state_d       = ST_RESP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = RESP_SLVERR;
            rsp_rdata_d   = '0;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q       <= ST_IDLE;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            wvalid_q      <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            awaddr_q      <= awaddr_d;
            wvalid_q      <= wvalid_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.M_AXI_AWVALID = awvalid_q;
    assign bus.M_AXI_AWADDR  = awaddr_q;
    assign bus.M_AXI_AWPROT  = AXPROT_DEFAULT;
    assign bus.M_AXI_WVALID  = wvalid_q;
    assign bus.M_AXI_WDATA   = wdata_q;
    assign bus.M_AXI_WSTRB   = wstrb_q;
    assign bus.M_AXI_BREADY  = bready_q;
    assign bus.M_AXI_ARVALID = arvalid_q;
    assign bus.M_AXI_ARADDR  = araddr_q;
    assign bus.M_AXI_ARPROT  = AXPROT_DEFAULT;
    assign bus.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_4_lite_mst.sv
// Bench for axi_4_lite_mst: directed scenarios plus randomized transactions
// against a cycle-count model of when each response must appear.
module tb_axi_4_lite_mst;
    import axi_4_lite_mst_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    axi_4_lite_mst_if #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW)) bus ();

    axi_4_lite_mst #(
        .C_AXI_ADDR_WIDTH(AW),
        .C_AXI_DATA_WIDTH(DW),
        .C_TIMEOUT_CYCLES(TMO)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Per-transaction stimulus and slave behaviour.
    logic          t_write;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_rdata;
    logic [SW-1:0] t_wstrb;
    logic [1:0]    t_bresp, t_rresp;
    int            t_aw_dly, t_w_dly, t_b_dly, t_ar_dly, t_r_dly, t_rsp_dly;
    bit            t_hang;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        bus.cmd_valid     = 1'b0;
        bus.cmd_write     = 1'b0;
        bus.cmd_addr      = '0;
        bus.cmd_wdata     = '0;
        bus.cmd_wstrb     = '0;
        bus.rsp_ready     = 1'b0;
        bus.M_AXI_AWREADY = 1'b0;
        bus.M_AXI_WREADY  = 1'b0;
        bus.M_AXI_BVALID  = 1'b0;
        bus.M_AXI_BRESP   = 2'b00;
        bus.M_AXI_ARREADY = 1'b0;
        bus.M_AXI_RVALID  = 1'b0;
        bus.M_AXI_RDATA   = '0;
        bus.M_AXI_RRESP   = 2'b00;
    endtask

    task automatic set_defaults();
        t_write = 1'b1; t_addr = '0; t_wdata = '0; t_rdata = '0; t_wstrb = '1;
        t_bresp = RESP_OKAY; t_rresp = RESP_OKAY;
        t_aw_dly = 0; t_w_dly = 0; t_b_dly = 0; t_ar_dly = 0; t_r_dly = 0;
        t_rsp_dly = 0; t_hang = 1'b0;
    endtask

    // Cycle (counted from the command handshake) on which the slave's response is taken.
    function automatic int resp_cycle();
        if (t_hang) return 1000;
        if (t_write) return ((t_aw_dly > t_w_dly) ? t_aw_dly : t_w_dly) + 2 + t_b_dly;
        return t_ar_dly + 2 + t_r_dly;
    endfunction

    task automatic run_txn();
        int            r_cyc = resp_cycle();
        bit            exp_tmo = (r_cyc > TMO);
        int            exp_lat = exp_tmo ? TMO + 1 : r_cyc + 1;
        logic [DW-1:0] exp_rdata = (exp_tmo || t_write) ? '0 : t_rdata;
        logic [1:0]    exp_resp = exp_tmo ? RESP_SLVERR : (t_write ? t_bresp : t_rresp);
        logic [63:0]   hold = '0;
        int  cyc = 0;
        int  aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0, rsp_wait = 0;
        bit  cmd_sent = 0, aw_got = 0, w_got = 0, b_done = 0, ar_got = 0, r_done = 0;
        bit  rsp_seen = 0, done = 0;

        for (int guard = 0; guard < 200 && !done; guard++) begin
            @(negedge clk);
            if (!cmd_sent) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_write = t_write;
                bus.cmd_addr  = t_addr;
                bus.cmd_wdata = t_wdata;
                bus.cmd_wstrb = t_wstrb;
                if (bus.cmd_ready) cmd_sent = 1;
            end else begin
                cyc++;
                bus.cmd_valid = 1'b0;
                if (t_write) begin
                    if (!(aw_got && w_got)) chk("bready_early", 64'(bus.M_AXI_BREADY), 64'(0));
                    bus.M_AXI_BVALID = 1'b0;
                    if (aw_got && w_got && !b_done && !t_hang) begin
                        if (b_wait >= t_b_dly) begin
                            bus.M_AXI_BVALID = 1'b1;
                            bus.M_AXI_BRESP  = t_bresp;
                            if (bus.M_AXI_BREADY) b_done = 1;
                        end else b_wait++;
                    end
                    bus.M_AXI_AWREADY = 1'b0;
                    if (!aw_got) begin
                        if (cyc <= TMO) chk("awvalid_hold", 64'(bus.M_AXI_AWVALID), 64'(1));
                        if (!t_hang && bus.M_AXI_AWVALID) begin
                            if (aw_wait >= t_aw_dly) begin
                                bus.M_AXI_AWREADY = 1'b1;
                                chk("awaddr", 64'(bus.M_AXI_AWADDR), 64'(t_addr));
                                chk("awprot", 64'(bus.M_AXI_AWPROT), 64'(0));
                                aw_got = 1;
                            end else aw_wait++;
                        end
                    end else chk("awvalid_drop", 64'(bus.M_AXI_AWVALID), 64'(0));
                    bus.M_AXI_WREADY = 1'b0;
                    if (!w_got) begin
                        if (cyc <= TMO) chk("wvalid_hold", 64'(bus.M_AXI_WVALID), 64'(1));
                        if (bus.M_AXI_WVALID) chk("wstrb", 64'(bus.M_AXI_WSTRB), 64'(t_wstrb));
                        if (!t_hang && bus.M_AXI_WVALID) begin
                            if (w_wait >= t_w_dly) begin
                                bus.M_AXI_WREADY = 1'b1;
                                chk("wdata", 64'(bus.M_AXI_WDATA), 64'(t_wdata));
                                w_got = 1;
                            end else w_wait++;
                        end
                    end else chk("wvalid_drop", 64'(bus.M_AXI_WVALID), 64'(0));
                end else begin
                    if (!ar_got) chk("rready_early", 64'(bus.M_AXI_RREADY), 64'(0));
                    bus.M_AXI_RVALID = 1'b0;
                    if (ar_got && !r_done && !t_hang) begin
                        if (r_wait >= t_r_dly) begin
                            bus.M_AXI_RVALID = 1'b1;
                            bus.M_AXI_RDATA  = t_rdata;
                            bus.M_AXI_RRESP  = t_rresp;
                            if (bus.M_AXI_RREADY) r_done = 1;
                        end else r_wait++;
                    end
                    bus.M_AXI_ARREADY = 1'b0;
                    if (!ar_got) begin
                        if (cyc <= TMO) chk("arvalid_hold", 64'(bus.M_AXI_ARVALID), 64'(1));
                        if (!t_hang && bus.M_AXI_ARVALID) begin
                            if (ar_wait >= t_ar_dly) begin
                                bus.M_AXI_ARREADY = 1'b1;
                                chk("araddr", 64'(bus.M_AXI_ARADDR), 64'(t_addr));
                                chk("arprot", 64'(bus.M_AXI_ARPROT), 64'(0));
                                ar_got = 1;
                            end else ar_wait++;
                        end
                    end else chk("arvalid_drop", 64'(bus.M_AXI_ARVALID), 64'(0));
                end
                if (exp_tmo && cyc == TMO + 1)
                    chk("tmo_axi_idle", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                                             bus.M_AXI_ARVALID, bus.M_AXI_RREADY}), 64'(0));
                bus.rsp_ready = 1'b0;
                if (bus.rsp_valid) begin
                    if (!rsp_seen) begin
                        rsp_seen = 1;
                        chk("rsp_latency", 64'(cyc), 64'(exp_lat));
                        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rdata));
                        chk("rsp_resp", 64'(bus.rsp_resp), 64'(exp_resp));
                        chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(exp_tmo));
                        hold = 64'({bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout});
                    end else begin
                        chk("rsp_stable", 64'({bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}), hold);
                    end
                    chk("cmd_ready_in_rsp", 64'(bus.cmd_ready), 64'(0));
                    if (rsp_wait >= t_rsp_dly) begin
                        bus.rsp_ready = 1'b1;
                        done = 1;
                    end else rsp_wait++;
                end
            end
        end
        if (!done) chk("txn_bound", 64'(0), 64'(1));
        @(negedge clk);
        slave_idle();
        chk("cmd_ready_after", 64'(bus.cmd_ready), 64'(1));
        chk("rsp_valid_after", 64'(bus.rsp_valid), 64'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({bus.cmd_ready, bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp,
                                 bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                                 bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.M_AXI_AWPROT,
                                 bus.M_AXI_ARPROT, bus.M_AXI_WSTRB}), 64'(0));
        chk({tag, "_wr"}, 64'({bus.M_AXI_AWADDR, bus.M_AXI_WDATA}), 64'(0));
        chk({tag, "_rd"}, 64'({bus.M_AXI_ARADDR, bus.rsp_rdata}), 64'(0));
    endtask

    task automatic reset_mid_txn();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h0000_0010;
        bus.cmd_wdata = 32'hA5A5_5A5A;
        bus.cmd_wstrb = 4'hF;
        chk("rst_cmd_accept", 64'(bus.cmd_ready), 64'(1));
        @(negedge clk);
        bus.cmd_valid     = 1'b0;
        bus.M_AXI_AWREADY = 1'b1;
        bus.M_AXI_WREADY  = 1'b1;
        @(negedge clk);
        bus.M_AXI_AWREADY = 1'b0;
        bus.M_AXI_WREADY  = 1'b0;
        chk("rst_in_wresp", 64'(bus.M_AXI_BREADY), 64'(1));
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("rst_async");
        @(negedge clk);
        slave_idle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", 64'(bus.rsp_valid), 64'(0));
        end
        chk("rst_idle_ready", 64'(bus.cmd_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran out of time, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        slave_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));

        // Write, always-ready slave: minimum latency.
        set_defaults();
        t_addr = 32'h4; t_wdata = 32'hDEAD_BEEF; t_wstrb = 4'hF;
        run_txn();

        // Write with AWREADY three cycles late and WREADY one cycle late.
        set_defaults();
        t_addr = 32'h20; t_wdata = 32'h0BAD_F00D; t_wstrb = 4'b0101;
        t_aw_dly = 3; t_w_dly = 1;
        run_txn();

        // Read with two wait cycles before RVALID.
        set_defaults();
        t_write = 1'b0; t_addr = 32'h8; t_rdata = 32'h1234_5678; t_r_dly = 2;
        run_txn();

        // DECERR passthrough with response backpressure.
        set_defaults();
        t_addr = 32'h30; t_wdata = 32'h5555_AAAA; t_bresp = RESP_DECERR; t_rsp_dly = 5;
        run_txn();

        // Read to a slave that never answers.
        set_defaults();
        t_write = 1'b0; t_addr = 32'h40; t_rdata = 32'hFFFF_FFFF; t_hang = 1'b1;
        run_txn();

        reset_mid_txn();

        for (int n = 0; n < 40; n++) begin
            t_write   = 1'($urandom_range(0, 1));
            t_addr    = $urandom & 32'hFFFF_FFFC;
            t_wdata   = $urandom;
            t_rdata   = $urandom;
            t_wstrb   = SW'($urandom_range(0, 15));
            t_bresp   = 2'($urandom_range(0, 3));
            t_rresp   = 2'($urandom_range(0, 3));
            t_aw_dly  = $urandom_range(0, 9);
            t_w_dly   = $urandom_range(0, 9);
            t_b_dly   = $urandom_range(0, 9);
            t_ar_dly  = $urandom_range(0, 9);
            t_r_dly   = $urandom_range(0, 9);
            t_rsp_dly = $urandom_range(0, 3);
            t_hang    = ($urandom_range(0, 7) == 0);
            run_txn();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
